// File: rtl/microwave_timer_ctrl_if.sv
// Keypad/button inputs and display/status outputs of the microwave cook-time controller.
// The master side drives the buttons; the controller uses the slave side.
interface microwave_timer_ctrl_if;
  logic       tick;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_closed;
  logic [3:0] min_digit;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic       magnetron_on;
  logic       done;
  logic [2:0] state_o;

  modport master (
    output tick, key_valid, key_digit, start, stop, clear, door_closed,
    input  min_digit, sec_tens, sec_units, magnetron_on, done, state_o
  );

  modport slave (
    input  tick, key_valid, key_digit, start, stop, clear, door_closed,
    output min_digit, sec_tens, sec_units, magnetron_on, done, state_o
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad entry into an M:ST BCD display, countdown on
// the 1 Hz tick, magnetron enable, and a timed done indication.
module microwave_timer_ctrl #(
  parameter int unsigned DONE_TICKS      = 3,
  parameter int unsigned QUICK_SECS_TENS = 3
) (
  input logic                   clk,
  input logic                   reset,
  microwave_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [3:0] cnt_q, cnt_d;

  logic time_zero;
  logic key_ok;
  logic start_ok;
  logic last_second;

  assign time_zero   = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);
  // A shift moves sec_units into sec_tens, so it must already be a legal tens digit.
  assign key_ok      = bus.key_valid && (bus.key_digit <= 4'd9) && (units_q <= 4'd5);
  assign start_ok    = bus.start && bus.door_closed;
  assign last_second = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q <= 4'd1);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    cnt_d   = cnt_q;

    if (bus.clear) begin
      state_d = StIdle;
      min_d   = 4'd0;
      tens_d  = 4'd0;
      units_d = 4'd0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        StIdle, StEntry: begin
          if (bus.stop && (state_q == StEntry)) begin
            state_d = StIdle;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
          end else if (start_ok && time_zero) begin
            state_d = StCook;
            min_d   = 4'd0;
            tens_d  = QUICK_SECS_TENS[3:0];
            units_d = 4'd0;
          end else if (start_ok && (state_q == StEntry)) begin
            state_d = StCook;
          end else if (key_ok) begin
            state_d = StEntry;
            min_d   = tens_q;
            tens_d  = units_q;
            units_d = bus.key_digit;
          end
        end
        StCook: begin
          if (!bus.door_closed || bus.stop) begin
            state_d = StPause;
          end else if (bus.tick) begin
            if (last_second) begin
              state_d = StDone;
              units_d = 4'd0;
              cnt_d   = 4'd0;
            end else if (units_q != 4'd0) begin
              units_d = units_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              units_d = 4'd9;
              tens_d  = tens_q - 4'd1;
            end else begin
              units_d = 4'd9;
              tens_d  = 4'd5;
              min_d   = min_q - 4'd1;
            end
          end
        end
        StPause: begin
          if (bus.stop) begin
            state_d = StIdle;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            units_d = 4'd0;
          end else if (start_ok) begin
            state_d = StCook;
          end
        end
        StDone: begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
          if (bus.tick) begin
            if (cnt_q + 4'd1 == DONE_TICKS[3:0]) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.min_digit    = min_q;
  assign bus.sec_tens     = tens_q;
  assign bus.sec_units    = units_q;
  assign bus.state_o      = state_q;
  assign bus.magnetron_on = (state_q == StCook);
  assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Self-checking bench for microwave_timer_ctrl: a vector table plus hand sequences, with
// expected display/state pushed to a scoreboard at drive time and popped after the edge.
module tb_microwave_timer_ctrl;

  localparam int ID = 0;
  localparam int EN = 1;
  localparam int CK = 2;
  localparam int PA = 3;
  localparam int DN = 4;

  typedef struct {
    logic       tick;
    logic       kv;
    logic [3:0] kd;
    logic       st;
    logic       sp;
    logic       cl;
    logic       door;
    logic [3:0] em;
    logic [3:0] et;
    logic [3:0] eu;
    logic [2:0] es;
  } vec_t;

  typedef struct {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] u;
    logic [2:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  microwave_timer_ctrl_if bus ();

  microwave_timer_ctrl #(
    .DONE_TICKS     (3),
    .QUICK_SECS_TENS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t mk(input int tick, input int kv, input int kd, input int st,
                              input int sp, input int cl, input int door, input int em,
                              input int et, input int eu, input int es);
    vec_t v;
    v.tick = tick[0]; v.kv = kv[0]; v.kd = kd[3:0]; v.st = st[0]; v.sp = sp[0];
    v.cl = cl[0]; v.door = door[0]; v.em = em[3:0]; v.et = et[3:0]; v.eu = eu[3:0];
    v.es = es[2:0];
    return v;
  endfunction

  task automatic chk(input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", what, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.tick = v.tick; bus.key_valid = v.kv; bus.key_digit = v.kd; bus.start = v.st;
    bus.stop = v.sp; bus.clear = v.cl; bus.door_closed = v.door;
    e.m = v.em; e.t = v.et; e.u = v.eu; e.s = v.es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("state_o", int'(bus.state_o), int'(e.s));
    chk("min_digit", int'(bus.min_digit), int'(e.m));
    chk("sec_tens", int'(bus.sec_tens), int'(e.t));
    chk("sec_units", int'(bus.sec_units), int'(e.u));
    chk("magnetron_on", int'(bus.magnetron_on), (e.s == 3'(CK)) ? 1 : 0);
    chk("done", int'(bus.done), (e.s == 3'(DN)) ? 1 : 0);
    step_no++;
  endtask

  initial begin
    reset = 1'b0;
    bus.tick = 0; bus.key_valid = 0; bus.key_digit = 0; bus.start = 0;
    bus.stop = 0; bus.clear = 0; bus.door_closed = 1;

    // Entry and countdown, pause/stop, 1:00 borrow
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, EN));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 1, 0, 1, 3, EN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 3, 0, EN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 3, 0, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 9, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 8, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 7, CK));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1, 1, 2, 7, CK));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 2, 7, CK));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 2, 7, PA));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 7, PA));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 1, 1, 2, 7, PA));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, ID));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, EN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, EN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, EN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 5, 9, CK));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ID));
    // Entry rejection
    vecs.push_back(mk(0, 1, 7, 0, 0, 0, 1, 0, 0, 7, EN));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1, 0, 0, 7, EN));
    vecs.push_back(mk(0, 1, 12, 0, 0, 0, 1, 0, 0, 7, EN));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ID));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 1, 0, 0, 4, EN));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1, 0, 4, 5, EN));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 4, 5, 1, EN));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 5, 1, 2, EN));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ID));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 1, 0, 0, 3, EN));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, ID));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ID));
    // Door open with tick, start with door open, resume
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, EN));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, EN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, PA));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, PA));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, PA));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 9, CK));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, ID));
    // Expiry and done hold
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, 0, 2, EN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 2, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, CK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 1, 0, 0, 0, DN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ID));
    // Start from ENTRY holding 0:00 behaves as quick-start
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, EN));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 3, 0, CK));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ID));

    // Reset held for two cycles overrides keys and start
    step(mk(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, ID));
    step(mk(0, 1, 2, 1, 0, 0, 1, 0, 0, 0, ID));
    reset = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ID));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ID));

    foreach (vecs[i]) step(vecs[i]);

    // Quick-start, ten ticks down to 0:20, then stop twice
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 3, 0, CK));
    for (int i = 1; i <= 10; i++) begin
      step(mk(1, 0, 0, 0, 0, 0, 1, 0, (30 - i) / 10, (30 - i) % 10, CK));
    end
    step(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 0, PA));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, ID));

    // Done counter advances only on ticks
    step(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, EN));
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, CK));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DN));
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ID));

    // Reset mid-cook
    step(mk(0, 1, 4, 0, 0, 0, 1, 0, 0, 4, EN));
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 4, CK));
    reset = 1'b0;
    step(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, ID));
    reset = 1'b1;
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ID));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
